// File: rtl/seq_adder_pkg.sv
// Shared types and helpers for the chunked sequential adder.
// Optional subtract support is enabled by defining SEQ_ADDER_SUB_EN.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/chunk_rca.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
// Also exposes the carry into the top bit for signed-overflow detection.
module chunk_rca #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    logic c_in;
    logic c_out;
    if (i == 0) begin : g_first
      assign c_in = ci;
    end else begin : g_rest
      assign c_in = g_fa[i-1].c_out;
    end
    assign s[i]  = a[i] ^ b[i] ^ c_in;
    assign c_out = (a[i] & b[i]) | (c_in & (a[i] ^ b[i]));
  end

  assign co       = g_fa[CHUNK-1].c_out;
  assign c_msb_in = g_fa[CHUNK-1].c_in;

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: one CHUNK-bit slice reused NCHUNK times per operation.
// Define SEQ_ADDER_SUB_EN to add the op_sub (a - b) input.
module seq_chunk_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEQ_ADDER_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = clog2_min1(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [CHUNK-1:0]  a_ch, b_ch, s_ch;
  logic              co_ch, cmsb_ch;
  logic              sub_w;

`ifdef SEQ_ADDER_SUB_EN
  assign sub_w = op_sub;
`else
  assign sub_w = 1'b0;
`endif

  chunk_rca #(.CHUNK(CHUNK)) u_rca (
    .a        (a_ch),
    .b        (b_ch),
    .ci       (carry_q),
    .s        (s_ch),
    .co       (co_ch),
    .c_msb_in (cmsb_ch)
  );

  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx_q == IW'(k)) begin
        a_ch = a_q[k*CHUNK +: CHUNK];
        b_ch = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub_w ? ~b : b;
          carry_d = sub_w | cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < NCHUNK; k++) begin
          if (idx_q == IW'(k)) sum_d[k*CHUNK +: CHUNK] = s_ch;
        end
        carry_d = co_ch;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST) begin
          cout_d  = co_ch;
          ovf_d   = cmsb_ch ^ co_ch;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
